// File: rtl/sum_accumulator.sv
// Accumulates a burst of COUNT {cout, sum} adder results into an ACC_W-bit total behind valid/ready.
// Build option: define SUM_ACC_SATURATE_EN to clamp the total to all ones once it carries out.
module sum_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_cout,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              overflow,
    output logic              busy
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;
    logic             acc_valid_reg;
    logic             busy_reg;

    logic [ACC_W:0]   operand;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_next;
    logic             accept;

    // The carry becomes operand bit DATA_W; everything above is zero.
    assign operand  = {{(ACC_W - DATA_W){1'b0}}, in_cout, in_sum};
    assign sum      = {1'b0, acc_reg} + operand;
    assign in_ready = (state_reg == ACCUM);
    assign accept   = in_ready && in_valid;

`ifdef SUM_ACC_SATURATE_EN
    // Once the burst has carried out, the total stays pinned at full scale.
    assign acc_next = (sum[ACC_W] || overflow_reg) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            acc_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg      <= '0;
                        count_reg    <= '0;
                        overflow_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_reg      <= acc_next;
                        overflow_reg <= overflow_reg | sum[ACC_W];
                        count_reg    <= count_reg + 1'b1;
                        // Result is flagged on the same edge that takes the final operand.
                        if (count_reg == LAST) begin
                            acc_valid_reg <= 1'b1;
                            state_reg     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        acc_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    acc_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign acc_out   = acc_reg;
    assign acc_valid = acc_valid_reg;
    assign overflow  = overflow_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: default, ACC_W=10 and COUNT=1 instances share one clock/reset.
module tb_sum_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      st = '0;
    logic [2:0]      co = '0;
    logic [2:0]      iv = '0;
    logic [2:0]      ar = '0;
    logic [2:0][7:0] sm = '0;
    logic [2:0]      ir, av, ov, bz;
    logic [15:0]     acc0, acc2;
    logic [9:0]      acc1;

    sum_accumulator u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .in_sum(sm[0]), .in_cout(co[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .acc_out(acc0), .acc_valid(av[0]),
        .acc_ready(ar[0]), .overflow(ov[0]), .busy(bz[0])
    );

    sum_accumulator #(.ACC_W(10)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .in_sum(sm[1]), .in_cout(co[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .acc_out(acc1), .acc_valid(av[1]),
        .acc_ready(ar[1]), .overflow(ov[1]), .busy(bz[1])
    );

    sum_accumulator #(.COUNT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .in_sum(sm[2]), .in_cout(co[2]),
        .in_valid(iv[2]), .in_ready(ir[2]), .acc_out(acc2), .acc_valid(av[2]),
        .acc_ready(ar[2]), .overflow(ov[2]), .busy(bz[2])
    );

    typedef struct packed {
        logic [15:0] acc;
        logic        ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int checks = 0;
    int errors = 0;
    int popped = 0;

`ifdef SUM_ACC_SATURATE_EN
    localparam logic [15:0] OVF_FINAL = 16'h03FF;
    localparam logic [15:0] OVF_THIRD = 16'h03FF;
`else
    localparam logic [15:0] OVF_FINAL = 16'h03FC;
    localparam logic [15:0] OVF_THIRD = 16'h01FD;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] acc_of(input int d);
        case (d)
            0:       return acc0;
            1:       return {6'b0, acc1};
            default: return acc2;
        endcase
    endfunction

    // Monitor: one pop per result handshake, independent of the stimulus thread.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_n && av[d] && ar[d]) begin
                exp_t e;
                int   sz;
                case (d)
                    0:       sz = q0.size();
                    1:       sz = q1.size();
                    default: sz = q2.size();
                endcase
                if (sz == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result dut%0d: got acc=%h with no expected entry", d, acc_of(d));
                end else begin
                    case (d)
                        0:       e = q0.pop_front();
                        1:       e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    popped++;
                    $display("result dut%0d acc=%h ovf=%b (expected acc=%h ovf=%b)",
                             d, acc_of(d), ov[d], e.acc, e.ovf);
                    chk($sformatf("dut%0d_acc", d), {16'h0, acc_of(d)}, {16'h0, e.acc});
                    chk($sformatf("dut%0d_ovf", d), {31'h0, ov[d]}, {31'h0, e.ovf});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_burst(input int d);
        st[d] = 1'b1;
        tick(1);
        st[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [8:0] op);
        int n;
        n = 0;
        {co[d], sm[d]} = op;
        iv[d] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ir[d] && n < 50);
        if (!ir[d]) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut%0d: in_ready got 0 required 1", d);
        end
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    task automatic finish_burst(input int d);
        int n;
        n = 0;
        ar[d] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (bz[d] && n < 20);
        chk($sformatf("dut%0d_busy_clear", d), {31'h0, bz[d]}, 32'h0);
        ar[d] = 1'b0;
        tick(1);
    endtask

    initial begin
        #12;
        chk("reset_acc", {16'h0, acc0}, 32'h0);
        chk("reset_acc_valid", {31'h0, av[0]}, 32'h0);
        chk("reset_in_ready", {31'h0, ir[0]}, 32'h0);
        chk("reset_overflow", {31'h0, ov[0]}, 32'h0);
        chk("reset_busy", {31'h0, bz[0]}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);

        // Basic burst: 0x010 + 0x100 + 0x100 + 0x1FF = 0x040F
        q0.push_back('{acc: 16'h040F, ovf: 1'b0});
        start_burst(0);
        chk("accum_busy", {31'h0, bz[0]}, 32'h1);
        chk("accum_in_ready", {31'h0, ir[0]}, 32'h1);
        send(0, 9'h010);
        send(0, 9'h100);
        send(0, 9'h100);
        send(0, 9'h1FF);
        chk("hold_acc_valid", {31'h0, av[0]}, 32'h1);
        chk("hold_in_ready", {31'h0, ir[0]}, 32'h0);
        finish_burst(0);

        // Gaps between operands, start pulses while busy, 5-cycle downstream stall
        q0.push_back('{acc: 16'h040F, ovf: 1'b0});
        start_burst(0);
        send(0, 9'h010);
        tick(1);
        start_burst(0);
        tick(1);
        chk("start_in_accum_acc", {16'h0, acc0}, 32'h10);
        send(0, 9'h100);
        tick(2);
        send(0, 9'h100);
        tick(2);
        send(0, 9'h1FF);
        for (int i = 0; i < 5; i++) begin
            chk("stall_acc_valid", {31'h0, av[0]}, 32'h1);
            chk("stall_acc", {16'h0, acc0}, 32'h040F);
            chk("stall_in_ready", {31'h0, ir[0]}, 32'h0);
            if (i == 2) start_burst(0);
            else tick(1);
        end
        ar[0] = 1'b1;
        st[0] = 1'b1;
        tick(1);
        st[0] = 1'b0;
        ar[0] = 1'b0;
        chk("start_with_ack_busy", {31'h0, bz[0]}, 32'h0);
        chk("start_with_ack_in_ready", {31'h0, ir[0]}, 32'h0);
        chk("idle_acc_retained", {16'h0, acc0}, 32'h040F);
        tick(1);

        // Asynchronous reset after two accepts, then a fresh burst of 4 x 0x001
        start_burst(0);
        send(0, 9'h001);
        send(0, 9'h001);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_acc", {16'h0, acc0}, 32'h0);
        chk("midreset_acc_valid", {31'h0, av[0]}, 32'h0);
        chk("midreset_busy", {31'h0, bz[0]}, 32'h0);
        chk("midreset_in_ready", {31'h0, ir[0]}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        chk("after_reset_idle", {31'h0, ir[0]}, 32'h0);
        q0.push_back('{acc: 16'h0004, ovf: 1'b0});
        start_burst(0);
        for (int i = 0; i < 4; i++) send(0, 9'h001);
        finish_burst(0);

        // ACC_W=10: four 0x1FF operands carry out on the third accept
        q1.push_back('{acc: OVF_FINAL, ovf: 1'b1});
        start_burst(1);
        send(1, 9'h1FF);
        send(1, 9'h1FF);
        chk("ovf_after_2", {31'h0, ov[1]}, 32'h0);
        chk("acc_after_2", {22'h0, acc1}, 32'h03FE);
        send(1, 9'h1FF);
        chk("ovf_after_3", {31'h0, ov[1]}, 32'h1);
        chk("acc_after_3", {22'h0, acc1}, {16'h0, OVF_THIRD});
        send(1, 9'h1FF);
        chk("ovf_after_4", {31'h0, ov[1]}, 32'h1);
        finish_burst(1);

        // COUNT=1: a single accept completes the burst
        q2.push_back('{acc: 16'h00AB, ovf: 1'b0});
        start_burst(2);
        send(2, 9'h0AB);
        chk("count1_acc_valid", {31'h0, av[2]}, 32'h1);
        finish_burst(2);

        tick(3);
        chk("q0_drained", q0.size(), 32'h0);
        chk("q1_drained", q1.size(), 32'h0);
        chk("q2_drained", q2.size(), 32'h0);
        chk("results_seen", popped, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
